// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Round-robin arbiter that shares one single-word SDRAM controller bus
//   between three requesters (0: I-cache, 1: D-cache, 2: DMA/GPU).
//   One access is in flight at a time. A watchdog forces completion when the
//   controller never answers. A two-cycle drain absorbs the controller's
//   possibly two-cycle done, so that done is never credited to the next grant.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | searching for a request, starting after the last grant
//   S_BUSY   | sdc_start held, waiting for sdc_done or watchdog expiry
//   S_DRAIN1 | one cycle that ignores any trailing sdc_done
//   S_DRAIN2 | waits for sdc_done to fall before arbitrating again
//
// Ports
//   clk, reset            system clock, async active-high reset
//   pN_addr/data/we       requester N access descriptor
//   pN_start              requester N request level
//   pN_q, pN_done         requester N read data and one-cycle completion
//   sdc_addr/data/we      access presented to the controller
//   sdc_start             request to the controller, held until sdc_done
//   sdc_q, sdc_done       controller read data and completion
//   arb_timeout           sticky watchdog-expiry flag
module sdram_arbiter #(
    parameter int          TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] TIMEOUT_Q      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] p0_addr,
    input  logic [31:0] p0_data,
    input  logic        p0_we,
    input  logic        p0_start,
    output logic [31:0] p0_q,
    output logic        p0_done,
    input  logic [23:0] p1_addr,
    input  logic [31:0] p1_data,
    input  logic        p1_we,
    input  logic        p1_start,
    output logic [31:0] p1_q,
    output logic        p1_done,
    input  logic [23:0] p2_addr,
    input  logic [31:0] p2_data,
    input  logic        p2_we,
    input  logic        p2_start,
    output logic [31:0] p2_q,
    output logic        p2_done,
    output logic [23:0] sdc_addr,
    output logic [31:0] sdc_data,
    output logic        sdc_we,
    output logic        sdc_start,
    input  logic [31:0] sdc_q,
    input  logic        sdc_done,
    output logic        arb_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN1, S_DRAIN2} state_t;

    localparam int               CNT_W   = 10;
    // The watchdog counts down from this value; expiry is at terminal count 0,
    // which lands on the TIMEOUT_CYCLES-th cycle spent in S_BUSY.
    localparam logic [CNT_W-1:0] WD_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       last_grant_q, last_grant_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [23:0]      sdc_addr_q, sdc_addr_d;
    logic [31:0]      sdc_data_q, sdc_data_d;
    logic             sdc_we_q, sdc_we_d;
    logic             sdc_start_q, sdc_start_d;
    logic [2:0][31:0] q_q, q_d;
    logic [2:0]       done_q, done_d;
    logic             arb_timeout_q, arb_timeout_d;

    logic [3:0]       req;
    logic             found;
    logic [1:0]       win;
    logic [1:0]       cand;

    // Bit 3 pads the vector so a 2-bit index never falls outside it.
    assign req = {1'b0, p2_start, p1_start, p0_start};

    function automatic logic [1:0] rr_port(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 3'd3) sum = sum - 3'd3;
        return sum[1:0];
    endfunction

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        wd_cnt_d      = wd_cnt_q;
        sdc_addr_d    = sdc_addr_q;
        sdc_data_d    = sdc_data_q;
        sdc_we_d      = sdc_we_q;
        sdc_start_d   = sdc_start_q;
        q_d           = q_q;
        done_d        = '0;
        arb_timeout_d = arb_timeout_q;
        found         = 1'b0;
        win           = '0;
        cand          = '0;

        case (state_q)
            S_IDLE: begin
                // Search starts one past the last grant, so the port granted
                // last is checked last.
                for (int i = 1; i <= 3; i++) begin
                    cand = rr_port(last_grant_q, 2'(i));
                    if (!found && req[cand]) begin
                        found = 1'b1;
                        win   = cand;
                    end
                end
                if (found) begin
                    case (win)
                        2'd1: begin
                            sdc_addr_d = p1_addr;
                            sdc_data_d = p1_data;
                            sdc_we_d   = p1_we;
                        end
                        2'd2: begin
                            sdc_addr_d = p2_addr;
                            sdc_data_d = p2_data;
                            sdc_we_d   = p2_we;
                        end
                        default: begin
                            sdc_addr_d = p0_addr;
                            sdc_data_d = p0_data;
                            sdc_we_d   = p0_we;
                        end
                    endcase
                    sdc_start_d = 1'b1;
                    grant_d     = win;
                    wd_cnt_d    = WD_LOAD;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                wd_cnt_d = wd_cnt_q - CNT_W'(1);
                if (sdc_done || (wd_cnt_q == '0)) begin
                    sdc_start_d     = 1'b0;
                    q_d[grant_q]    = sdc_done ? sdc_q : TIMEOUT_Q;
                    done_d[grant_q] = 1'b1;
                    last_grant_d    = grant_q;
                    state_d         = S_DRAIN1;
                    if (!sdc_done) arb_timeout_d = 1'b1;
                end
            end
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: if (!sdc_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            last_grant_q  <= 2'd2;
            wd_cnt_q      <= '0;
            sdc_addr_q    <= '0;
            sdc_data_q    <= '0;
            sdc_we_q      <= 1'b0;
            sdc_start_q   <= 1'b0;
            q_q           <= '0;
            done_q        <= '0;
            arb_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            wd_cnt_q      <= wd_cnt_d;
            sdc_addr_q    <= sdc_addr_d;
            sdc_data_q    <= sdc_data_d;
            sdc_we_q      <= sdc_we_d;
            sdc_start_q   <= sdc_start_d;
            q_q           <= q_d;
            done_q        <= done_d;
            arb_timeout_q <= arb_timeout_d;
        end
    end

    assign p0_q        = q_q[0];
    assign p1_q        = q_q[1];
    assign p2_q        = q_q[2];
    assign p0_done     = done_q[0];
    assign p1_done     = done_q[1];
    assign p2_done     = done_q[2];
    assign sdc_addr    = sdc_addr_q;
    assign sdc_data    = sdc_data_q;
    assign sdc_we      = sdc_we_q;
    assign sdc_start   = sdc_start_q;
    assign arb_timeout = arb_timeout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter. The bench plays both the requesters and
//   the SDRAM controller; each requester uses a distinct address so the
//   granted port can be identified from sdc_addr.
module tb_sdram_arbiter;

    localparam logic [23:0] A0 = 24'h000A00;
    localparam logic [23:0] A1 = 24'h000B11;
    localparam logic [23:0] A2 = 24'h000C22;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] p0_addr, p1_addr, p2_addr;
    logic [31:0] p0_data, p1_data, p2_data;
    logic        p0_we, p1_we, p2_we;
    logic        p0_start, p1_start, p2_start;
    logic [31:0] p0_q, p1_q, p2_q;
    logic        p0_done, p1_done, p2_done;
    logic [23:0] sdc_addr;
    logic [31:0] sdc_data;
    logic        sdc_we, sdc_start;
    logic [31:0] sdc_q;
    logic        sdc_done;
    logic        arb_timeout;

    int checks = 0;
    int fails  = 0;
    int done_cnt0 = 0, done_cnt1 = 0, done_cnt2 = 0;

    sdram_arbiter #(.TIMEOUT_CYCLES(16), .TIMEOUT_Q(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset),
        .p0_addr(p0_addr), .p0_data(p0_data), .p0_we(p0_we), .p0_start(p0_start),
        .p0_q(p0_q), .p0_done(p0_done),
        .p1_addr(p1_addr), .p1_data(p1_data), .p1_we(p1_we), .p1_start(p1_start),
        .p1_q(p1_q), .p1_done(p1_done),
        .p2_addr(p2_addr), .p2_data(p2_data), .p2_we(p2_we), .p2_start(p2_start),
        .p2_q(p2_q), .p2_done(p2_done),
        .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we), .sdc_start(sdc_start),
        .sdc_q(sdc_q), .sdc_done(sdc_done),
        .arb_timeout(arb_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (p0_done === 1'b1) done_cnt0++;
        if (p1_done === 1'b1) done_cnt1++;
        if (p2_done === 1'b1) done_cnt2++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        p0_start = 0; p1_start = 0; p2_start = 0;
        sdc_done = 0; sdc_q = '0;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    // Controller model: waits for sdc_start, stays busy 'gap' cycles, then
    // returns a two-cycle done. Ports that see their done drop their start.
    task automatic serve(input logic [31:0] qv, input int gap, output logic ok,
                         output logic [23:0] a, output logic [2:0] dv, output logic st2);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!ok) begin
                if (sdc_start === 1'b1) ok = 1'b1;
                else step();
            end
        end
        a = sdc_addr;
        repeat (gap) step();
        sdc_q = qv;
        sdc_done = 1'b1;
        step();
        dv = {p2_done, p1_done, p0_done};
        if (dv[0]) p0_start = 1'b0;
        if (dv[1]) p1_start = 1'b0;
        if (dv[2]) p2_start = 1'b0;
        step();
        st2 = sdc_start;
        sdc_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++;
        if ({sdc_start, sdc_we, p0_done, p1_done, p2_done, arb_timeout} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {sdc_start, sdc_we, p0_done, p1_done, p2_done, arb_timeout});
        end
        checks++;
        if ({sdc_addr, sdc_data, p0_q, p1_q, p2_q} !== '0) begin
            fails++;
            $display("FAIL reset_data: addr %h data %h q0 %h q1 %h q2 %h expected all 0",
                     sdc_addr, sdc_data, p0_q, p1_q, p2_q);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        p1_addr = 24'h000123; p1_we = 1'b0; p1_start = 1'b1;
        step();
        checks++;
        if (sdc_start !== 1'b1 || sdc_addr !== 24'h000123 || sdc_we !== 1'b0) begin
            fails++;
            $display("FAIL read_grant: start %b addr %h we %b expected 1 000123 0",
                     sdc_start, sdc_addr, sdc_we);
        end
        sdc_done = 1'b1; sdc_q = 32'hCAFEF00D;
        step();
        checks++;
        if (p1_done !== 1'b1 || p1_q !== 32'hCAFEF00D || sdc_start !== 1'b0) begin
            fails++;
            $display("FAIL read_done: done %b q %h start %b expected 1 cafef00d 0",
                     p1_done, p1_q, sdc_start);
        end
        checks++;
        if (p0_done !== 1'b0 || p2_done !== 1'b0 || p0_q !== 32'h0 || p2_q !== 32'h0) begin
            fails++;
            $display("FAIL read_others: d0 %b d2 %b q0 %h q2 %h expected 0 0 0 0",
                     p0_done, p2_done, p0_q, p2_q);
        end
        p1_start = 1'b0;
        step();
        checks++;
        if (p1_done !== 1'b0 || p1_q !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL read_pulse: done %b q %h expected 0 cafef00d", p1_done, p1_q);
        end
        sdc_done = 1'b0;
        step(); step();
        p1_addr = A1;
    endtask

    task automatic test_all_three();
        logic ok, st2;
        logic [23:0] a;
        logic [2:0] dv;
        logic [23:0] exp_a [3];
        int c0, c1, c2;
        exp_a[0] = A0; exp_a[1] = A1; exp_a[2] = A2;
        do_reset();
        c0 = done_cnt0; c1 = done_cnt1; c2 = done_cnt2;
        p0_start = 1; p1_start = 1; p2_start = 1;
        for (int k = 0; k < 3; k++) begin
            serve(32'h1000_0000 + k, 1, ok, a, dv, st2);
            checks++;
            if (ok !== 1'b1 || a !== exp_a[k]) begin
                fails++;
                $display("FAIL rr_order[%0d]: granted %b addr %h expected 1 %h", k, ok, a, exp_a[k]);
            end
            checks++;
            if (dv !== (3'b001 << k)) begin
                fails++;
                $display("FAIL rr_done[%0d]: got %b expected %b", k, dv, 3'b001 << k);
            end
            checks++;
            if (st2 !== 1'b0) begin
                fails++;
                $display("FAIL rr_no_grant_in_done[%0d]: sdc_start %b expected 0", k, st2);
            end
        end
        step(); step();
        checks++;
        if (done_cnt0 - c0 != 1 || done_cnt1 - c1 != 1 || done_cnt2 - c2 != 1) begin
            fails++;
            $display("FAIL rr_done_count: got %0d %0d %0d expected 1 1 1",
                     done_cnt0 - c0, done_cnt1 - c1, done_cnt2 - c2);
        end
        checks++;
        if (p1_q !== 32'h1000_0001) begin
            fails++;
            $display("FAIL rr_q1: got %h expected 10000001", p1_q);
        end
    endtask

    task automatic test_back_to_back();
        logic ok, st2;
        logic [23:0] a;
        logic [2:0] dv;
        logic [23:0] exp_a [3];
        exp_a[0] = A0; exp_a[1] = A2; exp_a[2] = A0;
        p0_start = 1; p2_start = 1;
        for (int k = 0; k < 3; k++) begin
            serve(32'h2000_0000 + k, 0, ok, a, dv, st2);
            if (k == 0) p0_start = 1'b1;
            checks++;
            if (ok !== 1'b1 || a !== exp_a[k]) begin
                fails++;
                $display("FAIL b2b_order[%0d]: granted %b addr %h expected 1 %h", k, ok, a, exp_a[k]);
            end
        end
        step(); step();
    endtask

    task automatic test_write_stable();
        logic ok;
        p2_addr = 24'hABCDEF; p2_data = 32'h12345678; p2_we = 1'b1; p2_start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!ok) begin
                step();
                if (sdc_start === 1'b1) ok = 1'b1;
            end
        end
        checks++;
        if (ok !== 1'b1 || sdc_addr !== 24'hABCDEF || sdc_data !== 32'h12345678 || sdc_we !== 1'b1) begin
            fails++;
            $display("FAIL write_issue: start %b addr %h data %h we %b expected 1 abcdef 12345678 1",
                     ok, sdc_addr, sdc_data, sdc_we);
        end
        p2_addr = 24'h000000; p2_data = 32'h0; p2_we = 1'b0;
        step(); step(); step();
        checks++;
        if (sdc_start !== 1'b1 || sdc_addr !== 24'hABCDEF || sdc_data !== 32'h12345678 || sdc_we !== 1'b1) begin
            fails++;
            $display("FAIL write_stable: start %b addr %h data %h we %b expected 1 abcdef 12345678 1",
                     sdc_start, sdc_addr, sdc_data, sdc_we);
        end
        sdc_done = 1'b1; sdc_q = 32'h55AA55AA;
        step();
        checks++;
        if (p2_done !== 1'b1 || p2_q !== 32'h55AA55AA) begin
            fails++;
            $display("FAIL write_done: done %b q %h expected 1 55aa55aa", p2_done, p2_q);
        end
        p2_start = 1'b0; sdc_done = 1'b0;
        step(); step();
        p2_addr = A2;
    endtask

    task automatic test_timeout();
        logic early;
        checks++;
        if (arb_timeout !== 1'b0) begin
            fails++;
            $display("FAIL to_pre: arb_timeout %b expected 0", arb_timeout);
        end
        p0_addr = A0; p0_we = 1'b0; p0_start = 1'b1;
        step();
        checks++;
        if (sdc_start !== 1'b1 || sdc_addr !== A0) begin
            fails++;
            $display("FAIL to_grant: start %b addr %h expected 1 %h", sdc_start, sdc_addr, A0);
        end
        early = 1'b0;
        repeat (15) begin
            step();
            if (p0_done !== 1'b0 || arb_timeout !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            fails++;
            $display("FAIL to_early: early completion %b expected 0", early);
        end
        step();
        checks++;
        if (p0_done !== 1'b1 || p0_q !== 32'hDEADBEEF || arb_timeout !== 1'b1 || sdc_start !== 1'b0) begin
            fails++;
            $display("FAIL to_fire: done %b q %h timeout %b start %b expected 1 deadbeef 1 0",
                     p0_done, p0_q, arb_timeout, sdc_start);
        end
        p0_start = 1'b0;
        step();
        checks++;
        if (p0_done !== 1'b0) begin
            fails++;
            $display("FAIL to_pulse: done %b expected 0", p0_done);
        end
        step(); step(); step();
        checks++;
        if (arb_timeout !== 1'b1) begin
            fails++;
            $display("FAIL to_sticky: arb_timeout %b expected 1", arb_timeout);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic ok, st2;
        logic [23:0] a;
        logic [2:0] dv;
        int c0, c1, c2;
        p1_start = 1'b1;
        step();
        checks++;
        if (sdc_start !== 1'b1 || sdc_addr !== A1) begin
            fails++;
            $display("FAIL rst_grant: start %b addr %h expected 1 %h", sdc_start, sdc_addr, A1);
        end
        step(); step();
        c0 = done_cnt0; c1 = done_cnt1; c2 = done_cnt2;
        reset = 1'b1;
        #1;
        checks++;
        if ({sdc_start, sdc_we, p0_done, p1_done, p2_done, arb_timeout} !== 6'b0 ||
            {sdc_addr, sdc_data, p0_q, p1_q, p2_q} !== '0) begin
            fails++;
            $display("FAIL rst_async: start %b addr %h q0 %h timeout %b expected all 0",
                     sdc_start, sdc_addr, p0_q, arb_timeout);
        end
        p1_start = 1'b0;
        step(); step();
        reset = 1'b0;
        step(); step();
        checks++;
        if (done_cnt0 != c0 || done_cnt1 != c1 || done_cnt2 != c2) begin
            fails++;
            $display("FAIL rst_no_done: done counts moved %0d %0d %0d expected 0 0 0",
                     done_cnt0 - c0, done_cnt1 - c1, done_cnt2 - c2);
        end
        p0_start = 1'b1; p1_start = 1'b1;
        step();
        checks++;
        if (sdc_start !== 1'b1 || sdc_addr !== A0) begin
            fails++;
            $display("FAIL rst_first_grant: start %b addr %h expected 1 %h", sdc_start, sdc_addr, A0);
        end
        serve(32'h3000_0000, 0, ok, a, dv, st2);
        checks++;
        if (dv !== 3'b001) begin
            fails++;
            $display("FAIL rst_first_done: got %b expected 001", dv);
        end
        serve(32'h3000_0001, 0, ok, a, dv, st2);
        checks++;
        if (ok !== 1'b1 || a !== A1 || dv !== 3'b010) begin
            fails++;
            $display("FAIL rst_second: granted %b addr %h done %b expected 1 %h 010", ok, a, dv, A1);
        end
        step(); step();
    endtask

    initial begin
        reset = 1'b1;
        p0_addr = A0; p1_addr = A1; p2_addr = A2;
        p0_data = 32'h0000_00D0; p1_data = 32'h0000_00D1; p2_data = 32'h0000_00D2;
        p0_we = 0; p1_we = 0; p2_we = 0;
        p0_start = 0; p1_start = 0; p2_start = 0;
        sdc_q = '0; sdc_done = 1'b0;

        test_reset();
        test_single_read();
        test_all_three();
        test_back_to_back();
        test_write_stable();
        test_timeout();
        test_reset_mid_busy();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
